// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: latches a/b/cin, then streams bit pairs LSB-first
// through one fulladder, assembling the sum in a shift register.

module fulladder (
   input  logic a,
   input  logic b,
   input  logic c,
   output logic sum,
   output logic carry
);
   assign sum   = a ^ b ^ c;
   assign carry = (a & b) | (a & c) | (b & c);
endmodule

module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);
   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] a_sr_q, a_sr_d, b_sr_q, b_sr_d, s_sr_q, s_sr_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             carry_q, carry_d, cout_q, cout_d, done_q, done_d;
   logic             fa_sum, fa_carry;

   fulladder u_fa (
      .a     (a_sr_q[0]),
      .b     (b_sr_q[0]),
      .c     (carry_q),
      .sum   (fa_sum),
      .carry (fa_carry)
   );

   always_comb begin
      state_d = state_q;
      a_sr_d  = a_sr_q;
      b_sr_d  = b_sr_q;
      s_sr_d  = s_sr_q;
      sum_d   = sum_q;
      cnt_d   = cnt_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      done_d  = 1'b0;
      case (state_q)
         S_IDLE, S_DONE: begin
            state_d = S_IDLE;
            if (start) begin
               state_d = S_RUN;
               a_sr_d  = a;
               b_sr_d  = b;
               carry_d = cin;
               cnt_d   = '0;
            end
         end
         S_RUN: begin
            a_sr_d  = {1'b0, a_sr_q[WIDTH-1:1]};
            b_sr_d  = {1'b0, b_sr_q[WIDTH-1:1]};
            s_sr_d  = {fa_sum, s_sr_q[WIDTH-1:1]};
            carry_d = fa_carry;
            cnt_d   = cnt_q + 1'b1;
            // Last bit: publish the shifted-in result, including this edge's sum bit.
            if (cnt_q == CW'(WIDTH-1)) begin
               sum_d   = {fa_sum, s_sr_q[WIDTH-1:1]};
               cout_d  = fa_carry;
               done_d  = 1'b1;
               cnt_d   = '0;
               state_d = S_DONE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         a_sr_q  <= '0;
         b_sr_q  <= '0;
         s_sr_q  <= '0;
         sum_q   <= '0;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_sr_q  <= a_sr_d;
         b_sr_q  <= b_sr_d;
         s_sr_q  <= s_sr_d;
         sum_q   <= sum_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         done_q  <= done_d;
      end
   end

   assign busy = (state_q == S_RUN);
   assign done = done_q;
   assign sum  = sum_q;
   assign cout = cout_q;
endmodule

// File: tb/tb_serial_adder.sv
// Randomized + directed bench for serial_adder; expected results come from
// plain integer addition of the operands.

module tb_serial_adder;
   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [W-1:0] a = '0, b = '0;
   logic         cin = 1'b0;
   logic         busy, done, cout;
   logic [W-1:0] sum;

   int n_vec = 0;
   int n_err = 0;
   logic [W:0] prev_res = '0;

   serial_adder #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
      .busy(busy), .done(done), .sum(sum), .cout(cout)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One isolated addition: checks latency, hold of the old result, and outcome.
   task automatic do_add(input logic [W-1:0] av, input logic [W-1:0] bv, input logic ci);
      logic [W:0] exp_v;
      int bcyc;
      exp_v = {1'b0, av} + {1'b0, bv} + {{W{1'b0}}, ci};
      start = 1'b1; a = av; b = bv; cin = ci;
      tick();
      start = 1'b0; a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      bcyc = 0;
      while (busy && bcyc < 20) begin
         chk("hold_result", {cout, sum}, prev_res);
         chk("no_early_done", done, 1'b0);
         bcyc++;
         tick();
      end
      chk("busy_cycles", bcyc, W);
      chk("done_rise", done, 1'b1);
      chk("result", {cout, sum}, exp_v);
      prev_res = exp_v;
      tick();
      chk("done_pulse_len", done, 1'b0);
      chk("result_held", {cout, sum}, exp_v);
   endtask

   initial begin
      int cnt, dones;
      logic [W:0] exp_v;

      #3;
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_sum", sum, '0);
      chk("rst_cout", cout, 1'b0);
      rst_n = 1'b1;
      repeat (3) tick();
      chk("post_rst_idle", {busy, done, cout, sum}, '0);

      do_add(8'h5A, 8'h3C, 1'b0);
      do_add(8'hFF, 8'h01, 1'b0);
      do_add(8'hFF, 8'hFF, 1'b1);
      do_add(8'h00, 8'h00, 1'b1);

      // Second start while busy must be ignored
      start = 1'b1; a = 8'h10; b = 8'h20; cin = 1'b0;
      tick();
      start = 1'b0;
      tick(); tick();
      start = 1'b1; a = 8'hFF; b = 8'hFF;
      tick();
      start = 1'b0;
      dones = 0;
      for (int i = 0; i < 20; i++) begin
         if (done) begin
            dones++;
            chk("ignore_result", {cout, sum}, 9'h030);
         end
         tick();
      end
      chk("ignore_done_count", dones, 1);
      prev_res = 9'h030;

      // Back-to-back with start held high
      start = 1'b1; a = 8'h01; b = 8'h01; cin = 1'b0;
      cnt = 0;
      do begin tick(); cnt++; end while (!done && cnt < 30);
      chk("b2b_first_done", done, 1'b1);
      chk("b2b_first", {cout, sum}, 9'h002);
      a = 8'h80; b = 8'h80;
      cnt = 0;
      do begin tick(); cnt++; end while (!done && cnt < 30);
      chk("b2b_spacing", cnt, W + 1);
      chk("b2b_second", {cout, sum}, 9'h100);
      start = 1'b0;
      tick();
      chk("b2b_stop", {busy, done}, 2'b00);
      prev_res = 9'h100;

      // Asynchronous reset in the middle of an operation
      start = 1'b1; a = 8'h0F; b = 8'h01; cin = 1'b0;
      tick();
      start = 1'b0;
      repeat (4) tick();
      chk("midop_busy_before", busy, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      chk("midop_busy", busy, 1'b0);
      chk("midop_sum", {cout, sum}, 9'h000);
      tick();
      rst_n = 1'b1;
      prev_res = '0;
      dones = 0;
      for (int i = 0; i < 12; i++) begin
         if (done) dones++;
         tick();
      end
      chk("midop_no_done", dones, 0);
      chk("midop_sum_after", {cout, sum}, 9'h000);
      do_add(8'h0F, 8'h01, 1'b0);

      // Random operands against integer addition
      for (int i = 0; i < 40; i++) begin
         do_add(W'($urandom), W'($urandom), 1'($urandom));
         if ($urandom_range(0, 1) == 1) tick();
      end

      // Random back-to-back stream with start held
      start = 1'b1; a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      exp_v = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
      tick();
      for (int k = 0; k < 10; k++) begin
         a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
         cnt = 0;
         while (!done && cnt < 30) begin tick(); cnt++; end
         chk("stream_spacing", cnt, W);
         chk("stream_result", {cout, sum}, exp_v);
         a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
         exp_v = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
         tick();
      end
      start = 1'b0;
      repeat (12) tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial WIDTH-bit adder.
- Latches two operands, then feeds them LSB-first, one bit pair per clock, into a single instance of the team's 1-bit `fulladder` (ports a, b, c -> sum, carry).
- Keeps the running carry in a flop and assembles the sum in a shift register.
- Sits directly upstream of `fulladder`: it is the sequencing stage that drives that adder's inputs and consumes its sum/carry outputs. This trades area for latency in narrow datapaths.

Parameters:
- WIDTH, 8, operand/result width in bits; legal values are WIDTH >= 2.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request to begin an addition; sampled only when busy=0.
- a  input  WIDTH  operand A; captured on the accepting edge.
- b  input  WIDTH  operand B; captured on the accepting edge.
- cin  input  1  carry-in; captured on the accepting edge.
- busy  output  1  high while bits are being processed.
- done  output  1  single-cycle pulse; result is valid.
- sum  output  WIDTH  registered result; held until the next completion.
- cout  output  1  registered carry-out; held with sum.

Behaviour:
- Interface (already decided): one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: busy=0, done=0, sum=0, cout=0, FSM=IDLE. Internal shift registers, carry flop and bit counter are all cleared to 0.
- FSM states and transitions:
  - IDLE -> RUN when start=1.
  - RUN -> DONE after the WIDTH-th bit edge.
  - DONE -> IDLE on the next edge, or DONE -> RUN if start=1 on that edge.
- Accept edge N (start=1 while busy=0, i.e. in IDLE or DONE):
  - a_sr<=a, b_sr<=b, carry<=cin, cnt<=0, busy<=1.
- Each RUN edge (N+1 .. N+WIDTH):
  - Apply fulladder(a_sr[0], b_sr[0], carry).
  - Shift the sum bit into the MSB of s_sr, shifting s_sr right.
  - carry<=fulladder carry.
  - Shift a_sr and b_sr right with zero fill.
  - cnt<=cnt+1.
- Completion edge N+WIDTH (cnt==WIDTH-1):
  - sum<=final s_sr value, including the bit computed on this edge.
  - cout<=carry out of the MSB.
  - busy<=0, done<=1, state<=DONE.
- Latency: busy=1 for exactly WIDTH cycles. done=1 for exactly one cycle, between edges N+WIDTH and N+WIDTH+1.
- Back-to-back operation: start may be asserted during the DONE cycle. It is accepted on that edge, so done and busy rise/fall on the same edge with no idle gap. Throughput is one result per WIDTH+1 cycles.
- start while busy=1 is ignored. Operand inputs are ignored while busy=1; changing them mid-operation has no effect.
- sum/cout change only at a completion edge. They are never updated mid-operation, and keep the previous result until the next completion.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1), unsigned. Wrap-around is expressed via cout only; no overflow flag.
- cnt width is ceil(log2(WIDTH)); it never exceeds WIDTH-1.
- Reset mid-operation: everything returns to its reset value immediately. No done pulse follows, and the aborted result never reaches sum/cout.
- start=1 held continuously: a new operation is accepted at each DONE cycle, using the a/b/cin values present on that edge.

Test Plan:
- Reset: assert rst_n=0 asynchronously between edges -> busy=0, done=0, sum=8'h00, cout=0 immediately; these stay unchanged after release while start=0.
- Basic add and latency (WIDTH=8): a=8'h5A, b=8'h3C, cin=0, start pulse at edge N -> busy high for 8 cycles; done=1 only in the cycle after edge N+8; sum=8'h96, cout=0; sum stays 8'h00 throughout the run.
- Carry chain: a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1. Then a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1. Then a=8'h00, b=8'h00, cin=1 -> sum=8'h01, cout=0.
- Ignore while busy: start with a=8'h10, b=8'h20. At cycle 3 pulse start with a=8'hFF, b=8'hFF -> exactly one done, result 8'h30, cout=0.
- Back-to-back: hold start=1 with a=8'h01, b=8'h01, then change to a=8'h80, b=8'h80 during the first DONE cycle -> first result 8'h02, cout=0. The second done arrives exactly 9 cycles after the first, with sum=8'h00, cout=1.
- Reset mid-op: start a=8'h0F, b=8'h01, then assert rst_n=0 after 4 bit edges -> busy=0 at once, no done, sum holds 8'h00. After release, a fresh start produces 8'h10.
